display_framebuffer: RTL and testbench

Double-buffered pixel memory feeding `display_driver`. A writer (renderer or serial loader) fills the back buffer through a valid/ready port while the driver scans the front buffer by `{row, column}`. A commit request makes the back buffer visible, but the swap happens only on the driver's `frame_complete` pulse, so the panel never shows a partial frame. A built-in clear engine zero-fills the back buffer.

---
 rtl/display_framebuffer_pkg.sv | 40 ++++
 rtl/display_framebuffer_if.sv | 37 +++
 rtl/display_framebuffer_bank.sv | 35 +++
 rtl/display_framebuffer.sv | 166 ++++++++++++++++
 tb/tb_display_framebuffer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_framebuffer_pkg.sv
// Shared types, width helpers and pixel layout constants for the
// double-buffered display framebuffer.
package display_pkg;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_PENDING = 2'd2
    } fb_state_e;

    // Channel order inside a packed pixel: R is the most significant channel.
    localparam int unsigned CH_B_IDX = 0;
    localparam int unsigned CH_G_IDX = 1;
    localparam int unsigned CH_R_IDX = 2;

    // Channel slices at the default 8-bit channel width.
    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

    // Pixel width: three colour channels.
    function automatic int unsigned pw_f(input int unsigned bitwidth);
        return 3 * bitwidth;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned addr_w_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Least significant bit of a channel within a packed pixel.
    function automatic int unsigned ch_lsb_f(input int unsigned ch, input int unsigned bitwidth);
        return ch * bitwidth;
    endfunction

endpackage

// File: rtl/display_framebuffer_if.sv
// Writer-side port of the framebuffer: pixel write channel plus the
// commit/clear control requests and status.
interface display_framebuffer_if #(
    parameter int unsigned segments = 1,
    parameter int unsigned rows     = 8,
    parameter int unsigned columns  = 32,
    parameter int unsigned bitwidth = 8
);
    localparam int unsigned SW = display_pkg::addr_w_f(segments);
    localparam int unsigned RW = display_pkg::addr_w_f(rows);
    localparam int unsigned CW = display_pkg::addr_w_f(columns);
    localparam int unsigned PW = display_pkg::pw_f(bitwidth);

    logic          wr_valid;
    logic          wr_ready;
    logic [SW-1:0] wr_segment;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_column;
    logic [PW-1:0] wr_data;
    logic          commit;
    logic          clear;
    logic          busy;
    logic          front;

    // Renderer / loader side.
    modport master (
        output wr_valid, wr_segment, wr_row, wr_column, wr_data, commit, clear,
        input  wr_ready, busy, front
    );

    // Framebuffer side.
    modport slave (
        input  wr_valid, wr_segment, wr_row, wr_column, wr_data, commit, clear,
        output wr_ready, busy, front
    );

endinterface

// File: rtl/display_framebuffer_bank.sv
// One segment's pixel store: simple dual-port RAM holding both buffers,
// one write port and one registered read port.
module framebuffer_bank #(
    parameter int unsigned AW = 9,
    parameter int unsigned PW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [PW-1:0] mem_r [DEPTH];

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, cleared by reset so the panel starts dark.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel memory for the display driver. The writer fills the
// back buffer; a commit swaps buffers only on the driver's frame_complete so
// a partial frame is never shown. A clear engine zero-fills the back buffer.
module display_framebuffer
    import display_pkg::*;
#(
    parameter  int unsigned segments = 1,
    parameter  int unsigned rows     = 8,
    parameter  int unsigned columns  = 32,
    parameter  int unsigned bitwidth = 8,
    localparam int unsigned PW       = pw_f(bitwidth),
    localparam int unsigned RW       = addr_w_f(rows),
    localparam int unsigned CW       = addr_w_f(columns)
) (
    input  logic                   clk,
    input  logic                   rst,
    display_framebuffer_if.slave   wr_if,
    input  logic                   frame_complete,
    input  logic [RW-1:0]          row,
    input  logic [CW-1:0]          column,
    output logic [segments*PW-1:0] pixel
);
    localparam int unsigned SW  = addr_w_f(segments);
    // Clear counter is laid out as {segment, row, column}.
    localparam int unsigned CTW = SW + RW + CW;
    localparam int unsigned AW  = 1 + RW + CW;
    localparam logic [CTW-1:0] CLR_LAST = CTW'(segments * rows * columns - 1);

    fb_state_e      state_r;
    fb_state_e      state_nxt_s;
    logic [CTW-1:0] clr_cnt_r;
    logic [CTW-1:0] clr_cnt_nxt_s;
    logic           commit_after_r;
    logic           commit_after_nxt_s;
    logic           front_r;
    logic           front_nxt_s;
    logic           wr_ready_s;
    logic           busy_s;

    logic [SW-1:0]  bw_seg_s;
    logic [RW-1:0]  bw_row_s;
    logic [CW-1:0]  bw_col_s;
    logic [PW-1:0]  bw_data_s;
    logic           bw_act_s;
    logic [AW-1:0]  waddr_s;
    logic [AW-1:0]  raddr_s;

    // Controller registers: state, clear counter, deferred commit, front index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            clr_cnt_r      <= '0;
            commit_after_r <= 1'b0;
            front_r        <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            clr_cnt_r      <= clr_cnt_nxt_s;
            commit_after_r <= commit_after_nxt_s;
            front_r        <= front_nxt_s;
        end
    end

    // Next-state logic; commit/clear only act in IDLE, frame_complete only in PENDING.
    always_comb begin
        state_nxt_s        = state_r;
        clr_cnt_nxt_s      = clr_cnt_r;
        commit_after_nxt_s = commit_after_r;
        front_nxt_s        = front_r;
        wr_ready_s         = 1'b0;
        busy_s             = 1'b1;
        case (state_r)
            ST_IDLE: begin
                wr_ready_s = 1'b1;
                busy_s     = 1'b0;
                if (wr_if.clear) begin
                    state_nxt_s        = ST_CLEAR;
                    clr_cnt_nxt_s      = '0;
                    commit_after_nxt_s = wr_if.commit;
                end else if (wr_if.commit) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    clr_cnt_nxt_s      = '0;
                    commit_after_nxt_s = 1'b0;
                    if (commit_after_r) begin
                        state_nxt_s = ST_PENDING;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + CTW'(1);
                end
            end
            ST_PENDING: begin
                if (frame_complete) begin
                    front_nxt_s = ~front_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s        = ST_IDLE;
                clr_cnt_nxt_s      = '0;
                commit_after_nxt_s = 1'b0;
            end
        endcase
    end

    assign wr_if.wr_ready = wr_ready_s;
    assign wr_if.busy     = busy_s;
    assign wr_if.front    = front_r;

    // Write mux: the clear engine owns the back buffer while clearing.
    always_comb begin
        bw_seg_s  = '0;
        bw_row_s  = '0;
        bw_col_s  = '0;
        bw_data_s = '0;
        bw_act_s  = 1'b0;
        if (state_r == ST_CLEAR) begin
            bw_seg_s  = clr_cnt_r[CW+RW +: SW];
            bw_row_s  = clr_cnt_r[CW +: RW];
            bw_col_s  = clr_cnt_r[0 +: CW];
            bw_data_s = '0;
            bw_act_s  = 1'b1;
        end else begin
            bw_seg_s  = wr_if.wr_segment;
            bw_row_s  = wr_if.wr_row;
            bw_col_s  = wr_if.wr_column;
            bw_data_s = wr_if.wr_data;
            bw_act_s  = wr_if.wr_valid & wr_ready_s;
        end
    end

    // Writes go to the back buffer, reads come from the front buffer.
    assign waddr_s = {~front_r, bw_row_s, bw_col_s};
    assign raddr_s = {front_r, row, column};

    for (genvar s = 0; s < segments; s++) begin : g_bank
        logic          bank_we_s;
        logic [PW-1:0] bank_rdata_s;

        assign bank_we_s = bw_act_s && (bw_seg_s == SW'(s));

        framebuffer_bank #(
            .AW (AW),
            .PW (PW)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we_s),
            .waddr (waddr_s),
            .wdata (bw_data_s),
            .raddr (raddr_s),
            .rdata (bank_rdata_s)
        );

        assign pixel[s*PW +: PW] = bank_rdata_s;
    end

endmodule

// File: tb/tb_display_framebuffer.sv
// Directed bench for display_framebuffer: single-segment DUT for the main
// behaviour, plus a two-segment DUT for the segment slice mapping.
module tb_display_framebuffer;
    import display_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fc;
    logic        fc2;
    logic [2:0]  row;
    logic [2:0]  row2;
    logic [4:0]  col;
    logic [4:0]  col2;
    logic [23:0] pixel;
    logic [47:0] pixel2;
    int          checks   = 0;
    int          failures = 0;
    int          n;

    always #5 clk = ~clk;

    display_framebuffer_if #(.segments(1)) fb_if ();
    display_framebuffer_if #(.segments(2)) fb2_if ();

    display_framebuffer #(.segments(1)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .wr_if          (fb_if),
        .frame_complete (fc),
        .row            (row),
        .column         (col),
        .pixel          (pixel)
    );

    display_framebuffer #(.segments(2)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .wr_if          (fb2_if),
        .frame_complete (fc2),
        .row            (row2),
        .column         (col2),
        .pixel          (pixel2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [2:0] r, input logic [4:0] c, input logic [23:0] d);
        fb_if.wr_segment = 1'b0;
        fb_if.wr_row     = r;
        fb_if.wr_column  = c;
        fb_if.wr_data    = d;
        fb_if.wr_valid   = 1'b1;
        tick();
        fb_if.wr_valid   = 1'b0;
    endtask

    task automatic wr2(input logic s, input logic [2:0] r, input logic [4:0] c, input logic [23:0] d);
        fb2_if.wr_segment = s;
        fb2_if.wr_row     = r;
        fb2_if.wr_column  = c;
        fb2_if.wr_data    = d;
        fb2_if.wr_valid   = 1'b1;
        tick();
        fb2_if.wr_valid   = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] r, input logic [4:0] c);
        row = r;
        col = c;
        tick();
    endtask

    task automatic swap1();
        fb_if.commit = 1'b1;
        tick();
        fb_if.commit = 1'b0;
        fc = 1'b1;
        tick();
        fc = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        fc = 1'b0; fc2 = 1'b0;
        row = 3'd0; col = 5'd0; row2 = 3'd0; col2 = 5'd0;
        fb_if.wr_valid = 1'b0; fb_if.wr_segment = 1'b0; fb_if.wr_row = 3'd0;
        fb_if.wr_column = 5'd0; fb_if.wr_data = 24'h0; fb_if.commit = 1'b0; fb_if.clear = 1'b0;
        fb2_if.wr_valid = 1'b0; fb2_if.wr_segment = 1'b0; fb2_if.wr_row = 3'd0;
        fb2_if.wr_column = 5'd0; fb2_if.wr_data = 24'h0; fb2_if.commit = 1'b0; fb2_if.clear = 1'b0;
        #1;
        check("rdy_in_reset", 64'(fb_if.wr_ready), 64'd1);
        repeat (3) tick();
        rst = 1'b1;
        check("rst_front", 64'(fb_if.front), 64'd0);
        check("rst_busy", 64'(fb_if.busy), 64'd0);
        check("rst_ready", 64'(fb_if.wr_ready), 64'd1);
        check("rst_pixel", 64'(pixel), 64'd0);

        // Fill back buffer (buffer 1), then clear and commit together.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                wr1(3'(r), 5'(c), 24'h123456);
            end
        end
        fb_if.clear = 1'b1;
        fb_if.commit = 1'b1;
        tick();
        fb_if.clear = 1'b0;
        fb_if.commit = 1'b0;
        n = 0;
        while (u_dut.state_r == ST_CLEAR && n < 2000) begin
            check("clr_busy", 64'(fb_if.busy), 64'd1);
            n++;
            tick();
        end
        check("clr_cycles", 64'(n), 64'd256);
        check("clr_then_pend", 64'(u_dut.state_r), 64'(ST_PENDING));
        repeat (5) tick();
        check("pend_busy", 64'(fb_if.busy), 64'd1);
        check("pend_ready", 64'(fb_if.wr_ready), 64'd0);
        fc = 1'b1;
        tick();
        fc = 1'b0;
        check("cc_front", 64'(fb_if.front), 64'd1);
        check("cc_busy", 64'(fb_if.busy), 64'd0);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                rd1(3'(r), 5'(c));
                check("cc_zero", 64'(pixel), 64'd0);
            end
        end

        // Write, commit with a simultaneous write, flip.
        wr1(3'd0, 5'd0, 24'hff0000);
        fb_if.wr_row = 3'd3; fb_if.wr_column = 5'd17; fb_if.wr_data = 24'h00ff00;
        fb_if.wr_valid = 1'b1;
        fb_if.commit = 1'b1;
        tick();
        fb_if.wr_valid = 1'b0;
        fb_if.commit = 1'b0;
        check("cm_busy", 64'(fb_if.busy), 64'd1);
        check("cm_ready", 64'(fb_if.wr_ready), 64'd0);
        rd1(3'd0, 5'd0);
        check("cm_old", 64'(pixel), 64'd0);
        fc = 1'b1;
        tick();
        fc = 1'b0;
        check("flip_front", 64'(fb_if.front), 64'd0);
        check("flip_n1_old", 64'(pixel), 64'd0);
        check("flip_busy", 64'(fb_if.busy), 64'd0);
        tick();
        check("flip_n2_new", 64'(pixel), 64'hff0000);
        rd1(3'd3, 5'd17);
        check("same_cyc_wr", 64'(pixel), 64'h00ff00);

        // frame_complete in IDLE is ignored.
        row = 3'd0; col = 5'd0;
        for (int i = 0; i < 3; i++) begin
            fc = 1'b1;
            tick();
            fc = 1'b0;
            tick();
            check("idle_fc_front", 64'(fb_if.front), 64'd0);
        end
        check("idle_fc_pix", 64'(pixel), 64'hff0000);

        // Commit with no frame_complete for 2000 cycles; writes refused.
        fb_if.commit = 1'b1;
        tick();
        fb_if.commit = 1'b0;
        fb_if.wr_row = 3'd0; fb_if.wr_column = 5'd0; fb_if.wr_data = 24'h0000ff;
        for (int i = 0; i < 2000; i++) begin
            fb_if.wr_valid = 1'b1;
            tick();
            if (i % 500 == 0) begin
                check("hold_ready", 64'(fb_if.wr_ready), 64'd0);
                check("hold_front", 64'(fb_if.front), 64'd0);
                check("hold_pix", 64'(pixel), 64'hff0000);
            end
        end
        fb_if.wr_valid = 1'b0;
        check("hold_busy", 64'(fb_if.busy), 64'd1);
        fc = 1'b1;
        tick();
        fc = 1'b0;
        tick();
        check("hold_swap_front", 64'(fb_if.front), 64'd1);
        check("hold_refused", 64'(pixel), 64'd0);

        // Commit during CLEAR is dropped.
        fb_if.clear = 1'b1;
        tick();
        fb_if.clear = 1'b0;
        n = 0;
        while (fb_if.busy && n < 2000) begin
            fb_if.commit = (n == 50) ? 1'b1 : 1'b0;
            n++;
            tick();
        end
        fb_if.commit = 1'b0;
        check("clr_only_cycles", 64'(n), 64'd256);
        check("clr_only_idle", 64'(u_dut.state_r), 64'(ST_IDLE));
        fc = 1'b1;
        tick();
        fc = 1'b0;
        check("drop_commit_front", 64'(fb_if.front), 64'd1);
        swap1();
        check("clr_show_front", 64'(fb_if.front), 64'd0);
        rd1(3'd0, 5'd0);
        check("clr_zero_00", 64'(pixel), 64'd0);
        rd1(3'd3, 5'd17);
        check("clr_zero_317", 64'(pixel), 64'd0);

        // Reset mid-CLEAR.
        swap1();
        check("pre_rst_front", 64'(fb_if.front), 64'd1);
        fb_if.clear = 1'b1;
        tick();
        fb_if.clear = 1'b0;
        n = 0;
        while (u_dut.clr_cnt_r != 9'd100 && n < 1000) begin
            n++;
            tick();
        end
        check("reach_cnt100", 64'(u_dut.clr_cnt_r), 64'd100);
        rst = 1'b0;
        #1;
        check("midrst_state", 64'(u_dut.state_r), 64'(ST_IDLE));
        check("midrst_front", 64'(fb_if.front), 64'd0);
        check("midrst_ready", 64'(fb_if.wr_ready), 64'd1);
        check("midrst_pixel", 64'(pixel), 64'd0);
        tick();
        rst = 1'b1;
        fb_if.clear = 1'b1;
        tick();
        fb_if.clear = 1'b0;
        n = 0;
        while (fb_if.busy && n < 2000) begin
            n++;
            tick();
        end
        check("reclr_cycles", 64'(n), 64'd256);

        // Two-segment slice mapping.
        wr2(1'b1, 3'd0, 5'd0, 24'habcdef);
        wr2(1'b0, 3'd0, 5'd0, 24'h111111);
        wr2(1'b1, 3'd7, 5'd31, 24'h0a0b0c);
        wr2(1'b0, 3'd7, 5'd31, 24'h202020);
        fb2_if.commit = 1'b1;
        tick();
        fb2_if.commit = 1'b0;
        fc2 = 1'b1;
        tick();
        fc2 = 1'b0;
        check("seg2_front", 64'(fb2_if.front), 64'd1);
        row2 = 3'd0; col2 = 5'd0;
        tick();
        check("seg1_00", 64'(pixel2[47:24]), 64'habcdef);
        check("seg0_00", 64'(pixel2[23:0]), 64'h111111);
        row2 = 3'd7; col2 = 5'd31;
        tick();
        check("seg1_731", 64'(pixel2[47:24]), 64'h0a0b0c);
        check("seg0_731", 64'(pixel2[23:0]), 64'h202020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
